// File: rtl/nrf24_controller_tx.sv
// nrf24_controller_tx: PTX-side controller for an nRF24L01 behind a byte-level
// SPI master. Boots and configures the radio, then per request loads a payload,
// pulses CE, waits for IRQ_n (or a timeout), reads/clears STATUS and reports.
//
// Optional feature macro: NRF24_TX_AUTOACK_EN
//   defined   -> EN_AA=0x01, SETUP_RETR=0x2F (auto-ack with retries, MAX_RT can fail)
//   undefined -> EN_AA=0x00, SETUP_RETR=0x00 (fire and forget, fail only on timeout)
//
// SPI handshake: spi_start pulses for one cycle with spi_tx/spi_hold_csn valid;
// spi_tx stays stable until the spi_done pulse; at least one idle cycle follows
// spi_done before the next spi_start. spi_hold_csn=0 marks the last byte of a command.
module nrf24_controller_tx #(
    parameter int BOOT_CYC        = 10_000_000,
    parameter int PWRUP_CYC       = 150_000,
    parameter int CE_PULSE_CYC    = 1_500,
    parameter int IRQ_TIMEOUT_CYC = 1_000_000,
    parameter int RF_CHANNEL      = 76,
    parameter int PAYLOAD_BYTES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       spi_start,
    output logic [7:0] spi_tx,
    input  logic [7:0] spi_rx,
    input  logic       spi_done,
    output logic       spi_hold_csn,
    output logic       CE,
    input  logic       IRQ_n,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       ready,
    output logic       tx_done,
    output logic       tx_fail,
    output logic [7:0] last_status
);

`ifdef NRF24_TX_AUTOACK_EN
    localparam logic [7:0] EN_AA_VAL      = 8'h01;
    localparam logic [7:0] SETUP_RETR_VAL = 8'h2F;
`else
    localparam logic [7:0] EN_AA_VAL      = 8'h00;
    localparam logic [7:0] SETUP_RETR_VAL = 8'h00;
`endif

    localparam int MAX_A   = (BOOT_CYC > PWRUP_CYC) ? BOOT_CYC : PWRUP_CYC;
    localparam int MAX_B   = (CE_PULSE_CYC > IRQ_TIMEOUT_CYC) ? CE_PULSE_CYC : IRQ_TIMEOUT_CYC;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_TOP    = CW'(CNT_MAX);
    localparam logic [CW-1:0] BOOT_LAST  = CW'(BOOT_CYC - 1);
    localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] CE_LAST    = CW'(CE_PULSE_CYC - 1);
    localparam logic [CW-1:0] IRQ_LAST   = CW'(IRQ_TIMEOUT_CYC - 1);

    localparam logic [7:0] RF_CH_VAL = 8'(RF_CHANNEL & 127);
    localparam logic [7:0] PW_VAL    = 8'(PAYLOAD_BYTES);
    localparam logic [5:0] LOAD_LAST = 6'(PAYLOAD_BYTES);
    localparam logic [5:0] CFG_LAST  = 6'd14;

    typedef enum logic [3:0] {
        S_BOOT, S_CFG, S_PWRUP, S_IDLE, S_LOAD,
        S_CE, S_WAIT_IRQ, S_STATUS, S_FLUSH, S_REPORT
    } state_t;

    // Per-byte phase: GAP guarantees an idle cycle before every spi_start.
    typedef enum logic [1:0] {PH_GAP, PH_START, PH_WAIT} phase_t;

    state_t        state, state_nxt;
    phase_t        phase;
    logic [5:0]    idx;
    logic [CW-1:0] cnt;
    logic [7:0]    data_q;
    logic          irq_s1, irq_s2;

    logic          is_spi;
    logic [7:0]    cur_byte;
    logic          cur_hold;
    logic [5:0]    last_idx;
    logic          byte_done;
    logic          seq_end;

    // Configuration command stream: seven register writes then FLUSH_TX.
    function automatic logic [7:0] cfg_byte(input logic [5:0] i);
        case (i)
            6'd0:    cfg_byte = 8'h20;
            6'd1:    cfg_byte = 8'h0E;
            6'd2:    cfg_byte = 8'h21;
            6'd3:    cfg_byte = EN_AA_VAL;
            6'd4:    cfg_byte = 8'h24;
            6'd5:    cfg_byte = SETUP_RETR_VAL;
            6'd6:    cfg_byte = 8'h25;
            6'd7:    cfg_byte = RF_CH_VAL;
            6'd8:    cfg_byte = 8'h26;
            6'd9:    cfg_byte = 8'h06;
            6'd10:   cfg_byte = 8'h31;
            6'd11:   cfg_byte = PW_VAL;
            6'd12:   cfg_byte = 8'h27;
            6'd13:   cfg_byte = 8'h70;
            6'd14:   cfg_byte = 8'hE1;
            default: cfg_byte = 8'h00;
        endcase
    endfunction

    // Current SPI byte, its CSN-hold flag and the last byte index of the command.
    always_comb begin
        is_spi   = 1'b0;
        cur_byte = 8'h00;
        cur_hold = 1'b0;
        last_idx = 6'd0;
        case (state)
            S_CFG: begin
                is_spi   = 1'b1;
                last_idx = CFG_LAST;
                cur_byte = cfg_byte(idx);
                cur_hold = !idx[0] && (idx != CFG_LAST);
            end
            S_LOAD: begin
                is_spi   = 1'b1;
                last_idx = LOAD_LAST;
                cur_byte = (idx == 6'd0) ? 8'hA0 : ((idx == 6'd1) ? data_q : 8'h00);
                cur_hold = (idx != LOAD_LAST);
            end
            S_STATUS: begin
                is_spi   = 1'b1;
                last_idx = 6'd1;
                cur_byte = (idx == 6'd0) ? 8'h27 : 8'h70;
                cur_hold = (idx == 6'd0);
            end
            S_FLUSH: begin
                is_spi   = 1'b1;
                last_idx = 6'd0;
                cur_byte = 8'hE1;
                cur_hold = 1'b0;
            end
            default: ;
        endcase
        byte_done = is_spi && (phase == PH_WAIT) && spi_done;
        seq_end   = byte_done && (idx == last_idx);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_BOOT;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:     if (cnt >= BOOT_LAST) state_nxt = S_CFG;
            S_CFG:      if (seq_end) state_nxt = S_PWRUP;
            S_PWRUP:    if (cnt >= PWRUP_LAST) state_nxt = S_IDLE;
            S_IDLE:     if (tx_req) state_nxt = S_LOAD;
            S_LOAD:     if (seq_end) state_nxt = S_CE;
            S_CE:       if (cnt >= CE_LAST) state_nxt = S_WAIT_IRQ;
            S_WAIT_IRQ: if (!irq_s2 || (cnt >= IRQ_LAST)) state_nxt = S_STATUS;
            S_STATUS:   if (seq_end) state_nxt = last_status[5] ? S_REPORT : S_FLUSH;
            S_FLUSH:    if (seq_end) state_nxt = S_REPORT;
            S_REPORT:   state_nxt = S_IDLE;
            default:    state_nxt = S_BOOT;
        endcase
    end

    // Outputs decoded from state; CE falls with an async reset because it is pure state.
    always_comb begin
        spi_start    = is_spi && (phase == PH_START);
        spi_tx       = cur_byte;
        spi_hold_csn = cur_hold;
        CE           = (state == S_CE);
        ready        = (state == S_IDLE);
        tx_done      = (state == S_REPORT) && last_status[5];
        tx_fail      = (state == S_REPORT) && !last_status[5];
    end

    // Cycle counter and SPI byte sequencing; both restart on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= 6'd0;
            phase <= PH_GAP;
        end else if (state_nxt != state) begin
            cnt   <= '0;
            idx   <= 6'd0;
            phase <= PH_GAP;
        end else begin
            if (cnt != CNT_TOP) cnt <= cnt + 1'b1;
            if (is_spi) begin
                case (phase)
                    PH_GAP:   phase <= PH_START;
                    PH_START: phase <= PH_WAIT;
                    default: if (spi_done) begin
                        phase <= PH_GAP;
                        idx   <= idx + 6'd1;
                    end
                endcase
            end
        end
    end

    // Payload capture on an accepted request; STATUS capture from the command byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q      <= 8'h00;
            last_status <= 8'h00;
        end else begin
            if (state == S_IDLE && tx_req) data_q <= tx_data;
            if (state == S_STATUS && byte_done && idx == 6'd0) last_status <= spi_rx;
        end
    end

    // Two-flop synchronizer for the asynchronous IRQ_n line (idle high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1 <= 1'b1;
            irq_s2 <= 1'b1;
        end else begin
            irq_s1 <= IRQ_n;
            irq_s2 <= irq_s1;
        end
    end

endmodule
